// File: rtl/ps2_receiver_if.sv
// PS/2 receiver signal bundle: raw device lines in, decoded byte and event pulses out.
// The master drives the device lines; the slave is the receiver core.
interface ps2_receiver_if;
  logic       ps2_clock;
  logic       ps2_data;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       ps2_error;

  modport master (
    output ps2_clock, ps2_data,
    input  ps2_key_pressed, ps2_out, ps2_error
  );

  modport slave (
    input  ps2_clock, ps2_data,
    output ps2_key_pressed, ps2_out, ps2_error
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver with glitch filter, parity/stop/timeout checking and break suppression.
// Byte and error pulses appear one cycle after the stop-bit edge is accepted; the device cannot be stalled.
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit SKIP_BREAK     = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  ps2_receiver_if.slave  ps2
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      out_q, out_d;
  logic            brk_q, brk_d;
  logic            key_q, key_d;
  logic            err_q, err_d;
  logic            fall;
  logic            timeout;
  logic            frame_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      out_q      <= '0;
      brk_q      <= 1'b0;
      key_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= ps2.ps2_clock;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2.ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      out_q      <= out_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      err_q      <= err_d;
    end
  end

  // The Nth consecutive differing sample flips the filtered level; a 1->0 flip is the sampling edge.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout  = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES)) && !fall;
  assign frame_ok = dat_s2_q && (^{shift_q, par_q});

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_s2_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    out_d     = out_q;
    brk_d     = brk_q;
    key_d     = 1'b0;
    err_d     = 1'b0;
    if (timeout) begin
      err_d     = 1'b1;
      bit_cnt_d = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: bit_cnt_d = '0;
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: par_d = dat_s2_q;
        default: begin
          // Break handling only sees good frames, so a corrupted byte leaves break_pending alone.
          if (!frame_ok) begin
            err_d = 1'b1;
          end else if (SKIP_BREAK && brk_q) begin
            brk_d = 1'b0;
          end else if (SKIP_BREAK && shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            out_d = shift_q;
            key_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign ps2.ps2_out         = out_q;
  assign ps2.ps2_key_pressed = key_q;
  assign ps2.ps2_error       = err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboarded bench for ps2_receiver: two instances (break skipping on and off) share one PS/2 line.
// Expected bytes are queued when frames are sent and popped when the DUT pulses ps2_key_pressed.
module tb_ps2_receiver;

  localparam int TO = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pclk = 1'b1;
  logic pdat = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;
  int err1   = 0;
  int err0   = 0;

  logic [7:0] exp1_q[$];
  logic [7:0] exp0_q[$];
  logic [7:0] e1_v, e0_v;
  logic       pk1, pe1, pk0, pe0;

  ps2_receiver_if if1();
  ps2_receiver_if if0();

  assign if1.ps2_clock = pclk;
  assign if1.ps2_data  = pdat;
  assign if0.ps2_clock = pclk;
  assign if0.ps2_data  = pdat;

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .SKIP_BREAK(1'b1)) dut1 (
    .clock(clk), .reset(rst), .ps2(if1));
  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .SKIP_BREAK(1'b0)) dut0 (
    .clock(clk), .reset(rst), .ps2(if0));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (if1.ps2_key_pressed) begin
        n_chk++;
        if (exp1_q.size() == 0) begin
          $display("FAIL sb1_unexpected_byte got=%02h required=no pulse", if1.ps2_out);
        end else begin
          e1_v = exp1_q.pop_front();
          if (if1.ps2_out !== e1_v) $display("FAIL sb1_byte got=%02h required=%02h", if1.ps2_out, e1_v);
          else n_pass++;
        end
      end
      if (if0.ps2_key_pressed) begin
        n_chk++;
        if (exp0_q.size() == 0) begin
          $display("FAIL sb0_unexpected_byte got=%02h required=no pulse", if0.ps2_out);
        end else begin
          e0_v = exp0_q.pop_front();
          if (if0.ps2_out !== e0_v) $display("FAIL sb0_byte got=%02h required=%02h", if0.ps2_out, e0_v);
          else n_pass++;
        end
      end
      if (if1.ps2_key_pressed || if1.ps2_error) begin
        n_chk++;
        if ((if1.ps2_key_pressed && (if1.ps2_error || pk1)) || (if1.ps2_error && pe1))
          $display("FAIL pulse_rule1 key=%b err=%b prev_key=%b prev_err=%b required=single exclusive pulse",
                   if1.ps2_key_pressed, if1.ps2_error, pk1, pe1);
        else n_pass++;
      end
      if (if0.ps2_key_pressed || if0.ps2_error) begin
        n_chk++;
        if ((if0.ps2_key_pressed && (if0.ps2_error || pk0)) || (if0.ps2_error && pe0))
          $display("FAIL pulse_rule0 key=%b err=%b prev_key=%b prev_err=%b required=single exclusive pulse",
                   if0.ps2_key_pressed, if0.ps2_error, pk0, pe0);
        else n_pass++;
      end
      if (if1.ps2_error) err1++;
      if (if0.ps2_error) err0++;
    end
    pk1 = if1.ps2_key_pressed;
    pe1 = if1.ps2_error;
    pk0 = if0.ps2_key_pressed;
    pe0 = if0.ps2_error;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input int half);
    pdat = b;
    wait_cyc(half);
    pclk = 1'b0;
    wait_cyc(half);
    pclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input int gap);
    ps2_bit(1'b0, half);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
    ps2_bit((~^b) ^ bad_par, half);
    ps2_bit(!bad_stop, half);
    pdat = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, input int half);
    ps2_bit(1'b0, half);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], half);
    pdat = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cyc(5);
    n_chk++; if (if1.ps2_out !== 8'h00) $display("FAIL reset_out1 got=%02h required=00", if1.ps2_out); else n_pass++;
    n_chk++; if (if1.ps2_key_pressed !== 1'b0) $display("FAIL reset_key1 got=%b required=0", if1.ps2_key_pressed); else n_pass++;
    n_chk++; if (if1.ps2_error !== 1'b0) $display("FAIL reset_err1 got=%b required=0", if1.ps2_error); else n_pass++;
    n_chk++; if (if0.ps2_out !== 8'h00) $display("FAIL reset_out0 got=%02h required=00", if0.ps2_out); else n_pass++;
    n_chk++; if (if0.ps2_key_pressed !== 1'b0) $display("FAIL reset_key0 got=%b required=0", if0.ps2_key_pressed); else n_pass++;
    n_chk++; if (if0.ps2_error !== 1'b0) $display("FAIL reset_err0 got=%b required=0", if0.ps2_error); else n_pass++;
    rst = 1'b0;
    wait_cyc(20);
  endtask

  task automatic test_single;
    int b1 = err1;
    int b0 = err0;
    exp1_q.push_back(8'h1C);
    exp0_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 1000, 100);
    n_chk++; if (exp1_q.size() !== 0) $display("FAIL single_missing1 got=%0d required=0", exp1_q.size()); else n_pass++;
    n_chk++; if (exp0_q.size() !== 0) $display("FAIL single_missing0 got=%0d required=0", exp0_q.size()); else n_pass++;
    n_chk++; if (err1 !== b1) $display("FAIL single_err1 got=%0d required=%0d", err1, b1); else n_pass++;
    n_chk++; if (if1.ps2_out !== 8'h1C) $display("FAIL single_out1 got=%02h required=1C", if1.ps2_out); else n_pass++;
  endtask

  task automatic test_break;
    exp1_q.push_back(8'h32);
    exp0_q.push_back(8'hF0);
    exp0_q.push_back(8'h1C);
    exp0_q.push_back(8'h32);
    send_frame(8'hF0, 1'b0, 1'b0, 50, 100);
    send_frame(8'h1C, 1'b0, 1'b0, 50, 100);
    send_frame(8'h32, 1'b0, 1'b0, 50, 100);
    n_chk++; if (exp1_q.size() !== 0) $display("FAIL break_missing1 got=%0d required=0", exp1_q.size()); else n_pass++;
    n_chk++; if (exp0_q.size() !== 0) $display("FAIL break_missing0 got=%0d required=0", exp0_q.size()); else n_pass++;
    n_chk++; if (if1.ps2_out !== 8'h32) $display("FAIL break_out1 got=%02h required=32", if1.ps2_out); else n_pass++;
  endtask

  task automatic test_frame_errors;
    int b1 = err1;
    int b0 = err0;
    send_frame(8'h1C, 1'b1, 1'b0, 50, 100);
    send_frame(8'h1C, 1'b0, 1'b1, 50, 100);
    n_chk++; if (err1 !== b1 + 2) $display("FAIL err_count1 got=%0d required=%0d", err1, b1 + 2); else n_pass++;
    n_chk++; if (err0 !== b0 + 2) $display("FAIL err_count0 got=%0d required=%0d", err0, b0 + 2); else n_pass++;
    n_chk++; if (if1.ps2_out !== 8'h32) $display("FAIL err_out_held got=%02h required=32", if1.ps2_out); else n_pass++;
    // A bad frame between F0 and its key must not cancel the pending break.
    exp0_q.push_back(8'hF0);
    exp0_q.push_back(8'h1C);
    exp0_q.push_back(8'h33);
    exp1_q.push_back(8'h33);
    send_frame(8'hF0, 1'b0, 1'b0, 50, 100);
    send_frame(8'h55, 1'b1, 1'b0, 50, 100);
    send_frame(8'h1C, 1'b0, 1'b0, 50, 100);
    send_frame(8'h33, 1'b0, 1'b0, 50, 100);
    n_chk++; if (err1 !== b1 + 3) $display("FAIL brkerr_count1 got=%0d required=%0d", err1, b1 + 3); else n_pass++;
    n_chk++; if (exp1_q.size() !== 0) $display("FAIL brkerr_missing1 got=%0d required=0", exp1_q.size()); else n_pass++;
    n_chk++; if (exp0_q.size() !== 0) $display("FAIL brkerr_missing0 got=%0d required=0", exp0_q.size()); else n_pass++;
    n_chk++; if (if1.ps2_out !== 8'h33) $display("FAIL brkerr_out1 got=%02h required=33", if1.ps2_out); else n_pass++;
  endtask

  task automatic test_timeout;
    int b1 = err1;
    int b0 = err0;
    send_partial(8'hA5, 5, 50);
    wait_cyc(TO + 1000);
    n_chk++; if (err1 !== b1 + 1) $display("FAIL timeout_err1 got=%0d required=%0d", err1, b1 + 1); else n_pass++;
    n_chk++; if (err0 !== b0 + 1) $display("FAIL timeout_err0 got=%0d required=%0d", err0, b0 + 1); else n_pass++;
    exp1_q.push_back(8'h1C);
    exp0_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 50, 100);
    n_chk++; if (exp1_q.size() !== 0) $display("FAIL timeout_next1 got=%0d required=0", exp1_q.size()); else n_pass++;
    n_chk++; if (err1 !== b1 + 1) $display("FAIL timeout_after_err1 got=%0d required=%0d", err1, b1 + 1); else n_pass++;
  endtask

  task automatic test_glitch;
    int b1 = err1;
    pdat = 1'b0;
    wait_cyc(3);
    pclk = 1'b0;
    wait_cyc(5);
    pclk = 1'b1;
    wait_cyc(3);
    pdat = 1'b1;
    wait_cyc(50);
    exp1_q.push_back(8'h4A);
    exp0_q.push_back(8'h4A);
    send_frame(8'h4A, 1'b0, 1'b0, 50, 100);
    n_chk++; if (exp1_q.size() !== 0) $display("FAIL glitch_next1 got=%0d required=0", exp1_q.size()); else n_pass++;
    n_chk++; if (if1.ps2_out !== 8'h4A) $display("FAIL glitch_out1 got=%02h required=4A", if1.ps2_out); else n_pass++;
    n_chk++; if (err1 !== b1) $display("FAIL glitch_err1 got=%0d required=%0d", err1, b1); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int b1 = err1;
    send_partial(8'h29, 4, 50);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(50);
    n_chk++; if (if1.ps2_out !== 8'h00) $display("FAIL rstmid_out1 got=%02h required=00", if1.ps2_out); else n_pass++;
    exp1_q.push_back(8'h29);
    exp0_q.push_back(8'h29);
    send_frame(8'h29, 1'b0, 1'b0, 50, 100);
    n_chk++; if (exp1_q.size() !== 0) $display("FAIL rstmid_next1 got=%0d required=0", exp1_q.size()); else n_pass++;
    n_chk++; if (if1.ps2_out !== 8'h29) $display("FAIL rstmid_out_after got=%02h required=29", if1.ps2_out); else n_pass++;
    n_chk++; if (err1 !== b1) $display("FAIL rstmid_err1 got=%0d required=%0d", err1, b1); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int b0 = err0;
    logic [7:0] seq [3] = '{8'hE0, 8'h75, 8'h16};
    foreach (seq[i]) begin
      exp1_q.push_back(seq[i]);
      exp0_q.push_back(seq[i]);
    end
    foreach (seq[i]) send_frame(seq[i], 1'b0, 1'b0, 50, (i == 2) ? 100 : 0);
    n_chk++; if (exp1_q.size() !== 0) $display("FAIL b2b_missing1 got=%0d required=0", exp1_q.size()); else n_pass++;
    n_chk++; if (exp0_q.size() !== 0) $display("FAIL b2b_missing0 got=%0d required=0", exp0_q.size()); else n_pass++;
    n_chk++; if (if0.ps2_out !== 8'h16) $display("FAIL b2b_out0 got=%02h required=16", if0.ps2_out); else n_pass++;
    n_chk++; if (err0 !== b0) $display("FAIL b2b_err0 got=%0d required=%0d", err0, b0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    wait_cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized samples needed to accept a ps2_clock level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000: clock cycles without an accepted ps2_clock falling edge before an in-progress frame is abandoned.
REQ-003 The block SHALL have parameter SKIP_BREAK, default 1: when 1, break sequences (0xF0 plus the following byte) are suppressed.
REQ-004 clock  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ps2_clock  input  1  raw PS/2 device clock; asynchronous to clock.
REQ-007 ps2_data  input  1  raw PS/2 device data; asynchronous to clock.
REQ-008 ps2_key_pressed  output  1  one-cycle pulse: ps2_out holds a new delivered byte.
REQ-009 ps2_out  output  8  last delivered scancode byte; held between deliveries.
REQ-010 ps2_error  output  1  one-cycle pulse: a frame was discarded (parity, stop or timeout).

Function
REQ-011 ps2_clock and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 The filtered ps2_clock level SHALL change only after FILTER_LEN consecutive synchronized samples at the new level; shorter glitches SHALL be ignored.
REQ-013 An accepted falling edge (filtered level 1 -> 0) SHALL sample the synchronized ps2_data in the same cycle.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: a sampled 0 (start bit) SHALL move to DATA with the bit counter at 0; a sampled 1 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-016 DATA: each sample SHALL shift into the byte LSB first; after the 8th bit the FSM SHALL move to PARITY.
REQ-017 PARITY: the sample SHALL be stored; the FSM SHALL move to STOP.
REQ-018 STOP: the frame SHALL be valid only if the sample is 1 and the 8 data bits plus the parity bit have an odd number of ones; in either case the FSM SHALL return to IDLE.
REQ-019 A valid frame SHALL update ps2_out and pulse ps2_key_pressed for exactly one cycle, on the clock edge after the stop-bit edge is accepted, unless REQ-021 suppresses it.
REQ-020 An invalid frame SHALL leave ps2_out unchanged and pulse ps2_error for one cycle, with the same timing as REQ-019.
REQ-021 If SKIP_BREAK=1, a valid 0xF0 SHALL set break_pending and be suppressed. The next valid byte SHALL be suppressed and SHALL clear break_pending.
REQ-022 If SKIP_BREAK=0, every valid byte SHALL be delivered, including 0xF0.
REQ-023 0xE0 prefixes SHALL always be delivered as ordinary bytes.
REQ-024 An invalid frame SHALL NOT clear break_pending.
REQ-025 The timeout counter SHALL clear on every accepted falling edge and while in IDLE. Otherwise it SHALL increment and saturate.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES outside IDLE, the FSM SHALL go to IDLE, discard the partial byte and pulse ps2_error once.
REQ-027 ps2_key_pressed and ps2_error SHALL never be asserted in the same cycle, nor for more than one consecutive cycle.
REQ-028 Byte throughput SHALL be unlimited: back-to-back frames, with a start edge immediately following a stop edge, SHALL each be received.

Reset
REQ-029 While reset is high, all of the following SHALL hold:
- FSM in IDLE
- bit counter, timeout counter and break_pending at 0
- filtered clock level and synchronizer flops at 1
- ps2_out = 0x00, ps2_key_pressed = 0, ps2_error = 0
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no pulse. After release, reception SHALL resume at the next start bit.

Verification
REQ-031 Frame 0x1C (parity 0, stop 1), PS/2 clock period 2000 cycles -> one ps2_key_pressed pulse, ps2_out = 0x1C, no ps2_error.
REQ-032 SKIP_BREAK=1, frames 0xF0 (parity 1), 0x1C, 0x32 -> exactly one pulse, ps2_out = 0x32. With SKIP_BREAK=0 -> three pulses, ps2_out = 0xF0, 0x1C, 0x32 in order.
REQ-033 Frame 0x1C with parity bit 1, then frame 0x1C with stop bit 0 -> two ps2_error pulses, no ps2_key_pressed, ps2_out unchanged from its prior value.
REQ-034 Start bit plus 5 data bits, then ps2_clock held high for 50000+ cycles -> one ps2_error pulse. A following valid 0x1C frame is then received correctly.
REQ-035 A ps2_clock low glitch of 5 cycles (FILTER_LEN=8) during IDLE with ps2_data=0 -> no state change. A following valid frame is received.
REQ-036 Reset pulsed after the 4th data bit of a frame, then a full valid 0x29 frame -> no pulse before the 0x29 frame, then one pulse with ps2_out = 0x29.
